// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the eip/ebp/esp register set: select codes, stack ops, FSM states.
package reg_writeback_pkg;

    localparam int unsigned SEL_W      = 4;
    localparam int unsigned STACK_OP_W = 2;
    localparam int unsigned LEN_W      = 4;

    // Select codes shared with the read selector so both sides decode identically
    localparam logic [SEL_W-1:0] SEL_ESP1 = 4'h1;
    localparam logic [SEL_W-1:0] SEL_EBP  = 4'h2;
    localparam logic [SEL_W-1:0] SEL_IMM  = 4'h3;
    localparam logic [SEL_W-1:0] SEL_ESP2 = 4'h4;

    typedef enum logic [STACK_OP_W-1:0] {
        STACK_NONE = 2'b00,
        STACK_PUSH = 2'b01,
        STACK_POP  = 2'b10,
        STACK_RSVD = 2'b11
    } stack_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PH1  = 2'b01,
        ST_PH2  = 2'b10
    } state_e;

    // Control fields captured when a transaction is accepted
    typedef struct packed {
        logic [SEL_W-1:0] sel1;
        logic [SEL_W-1:0] sel2;
        stack_op_e        stack_op;
        logic [LEN_W-1:0] insn_len;
        logic             jmp_valid;
    } wb_ctrl_t;

    // Both esp aliases decode to the same register
    function automatic logic sel_is_esp(input logic [SEL_W-1:0] sel);
        return (sel == SEL_ESP1) || (sel == SEL_ESP2);
    endfunction

endpackage

// File: rtl/reg_writeback.sv
// Two-phase write side of the eip/ebp/esp register set with push/pop and eip advance/jump.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_EIP  = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] RESET_ESP  = WIDTH'(32'h0000_1000),
    parameter int unsigned      STACK_STEP = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SEL_W-1:0]      wr_sel1,
    input  logic [SEL_W-1:0]      wr_sel2,
    input  logic [WIDTH-1:0]      wr_data1,
    input  logic [WIDTH-1:0]      wr_data2,
    input  logic [STACK_OP_W-1:0] stack_op,
    input  logic [LEN_W-1:0]      insn_len,
    input  logic                  jmp_valid,
    input  logic [WIDTH-1:0]      jmp_target,
    output logic [WIDTH-1:0]      eip,
    output logic [WIDTH-1:0]      ebp,
    output logic [WIDTH-1:0]      esp,
    output logic                  done
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    state_e           state;
    wb_ctrl_t         ctrl_q;
    logic [WIDTH-1:0] data1_q;
    logic [WIDTH-1:0] data2_q;
    logic [WIDTH-1:0] jmp_target_q;

    // Transaction FSM: latch operands in IDLE, commit sel1/push in PH1, sel2/pop/eip in PH2
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            wr_ready     <= 1'b1;
            done         <= 1'b0;
            eip          <= RESET_EIP;
            esp          <= RESET_ESP;
            ebp          <= '0;
            ctrl_q       <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            jmp_target_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_valid && wr_ready) begin
                        ctrl_q.sel1      <= wr_sel1;
                        ctrl_q.sel2      <= wr_sel2;
                        ctrl_q.stack_op  <= stack_op_e'(stack_op);
                        ctrl_q.insn_len  <= insn_len;
                        ctrl_q.jmp_valid <= jmp_valid;
                        data1_q          <= wr_data1;
                        data2_q          <= wr_data2;
                        jmp_target_q     <= jmp_target;
                        wr_ready         <= 1'b0;
                        state            <= ST_PH1;
                    end
                end
                ST_PH1: begin
                    // Later assignment wins: an explicit esp write overrides the push
                    if (ctrl_q.stack_op == STACK_PUSH) begin
                        esp <= esp - STEP;
                    end
                    if (sel_is_esp(ctrl_q.sel1)) begin
                        esp <= data1_q;
                    end else if (ctrl_q.sel1 == SEL_EBP) begin
                        ebp <= data1_q;
                    end
                    state <= ST_PH2;
                end
                ST_PH2: begin
                    if (sel_is_esp(ctrl_q.sel2)) begin
                        esp <= data2_q;
                    end else begin
                        if (ctrl_q.sel2 == SEL_EBP) begin
                            ebp <= data2_q;
                        end
                        if (ctrl_q.stack_op == STACK_POP) begin
                            esp <= esp + STEP;
                        end
                    end
                    eip      <= ctrl_q.jmp_valid ? jmp_target_q
                                                 : eip + WIDTH'(ctrl_q.insn_len);
                    done     <= 1'b1;
                    wr_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    wr_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: driver predicts retire state, monitor checks on done.
module tb_reg_writeback;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_sel1 = '0;
    logic [3:0]  wr_sel2 = '0;
    logic [31:0] wr_data1 = '0;
    logic [31:0] wr_data2 = '0;
    logic [1:0]  stack_op = '0;
    logic [3:0]  insn_len = '0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = '0;
    logic [31:0] eip, ebp, esp;
    logic        done;

    reg_writeback #(
        .WIDTH      (32),
        .RESET_EIP  (32'h0000_0000),
        .RESET_ESP  (32'h0000_1000),
        .STACK_STEP (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sel1    (wr_sel1),
        .wr_sel2    (wr_sel2),
        .wr_data1   (wr_data1),
        .wr_data2   (wr_data2),
        .stack_op   (stack_op),
        .insn_len   (insn_len),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .eip        (eip),
        .ebp        (ebp),
        .esp        (esp),
        .done       (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] eip;
        logic [31:0] ebp;
        logic [31:0] esp;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    // Architectural model of the register set
    logic [31:0] m_eip = 32'h0;
    logic [31:0] m_ebp = 32'h0;
    logic [31:0] m_esp = 32'h1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_esp(input logic [3:0] s);
        return s == 4'h1 || s == 4'h4;
    endfunction

    // Apply one transaction to the model following the architectural rules
    task automatic model_apply(input logic [3:0] s1, input logic [3:0] s2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [1:0] so, input logic [3:0] len,
                               input logic jv, input logic [31:0] jt);
        if (so == 2'b01) m_esp = m_esp - 32'd4;
        if (is_esp(s1)) m_esp = d1;
        else if (s1 == 4'h2) m_ebp = d1;
        if (is_esp(s2)) m_esp = d2;
        else begin
            if (s2 == 4'h2) m_ebp = d2;
            if (so == 2'b10) m_esp = m_esp + 32'd4;
        end
        m_eip = jv ? jt : m_eip + {28'd0, len};
    endtask

    task automatic scramble();
        wr_sel1    = 4'($urandom);
        wr_sel2    = 4'($urandom);
        wr_data1   = $urandom;
        wr_data2   = $urandom;
        stack_op   = 2'($urandom);
        insn_len   = 4'($urandom);
        jmp_valid  = 1'($urandom);
        jmp_target = $urandom;
    endtask

    // Present one transaction; returns at the negedge after the accept edge
    task automatic issue(input logic [3:0] s1, input logic [3:0] s2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [1:0] so, input logic [3:0] len,
                         input logic jv, input logic [31:0] jt, input bit track);
        int waited = 0;
        exp_t e;
        @(negedge clock);
        while (!wr_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!wr_ready) begin
            check("ready_timeout", {31'd0, wr_ready}, 32'd1);
            return;
        end
        wr_sel1 = s1; wr_sel2 = s2; wr_data1 = d1; wr_data2 = d2;
        stack_op = so; insn_len = len; jmp_valid = jv; jmp_target = jt;
        wr_valid = 1'b1;
        if (track) begin
            model_apply(s1, s2, d1, d2, so, len, jv, jt);
            e.eip = m_eip; e.ebp = m_ebp; e.esp = m_esp;
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
        @(negedge clock);
        wr_valid = 1'b0;
        scramble();
    endtask

    // Monitor: compare retire state against the scoreboard whenever done is seen
    bit done_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("eip", eip, e.eip);
                    check("ebp", ebp, e.ebp);
                    check("esp", esp, e.esp);
                    check("retire_cycle", 32'(cyc), 32'(e.cyc));
                    check("ready_at_retire", {31'd0, wr_ready}, 32'd1);
                end
                if (done_prev) check("done_width", 32'd2, 32'd1);
            end
            done_prev = done;
        end
    end

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 30) begin
            @(negedge clock);
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] s1, s2;
        scramble();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_eip", eip, 32'h0);
        check("rst_esp", esp, 32'h1000);
        check("rst_ebp", ebp, 32'h0);
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);

        // ebp write in phase 1, visible before retire
        issue(4'h2, 4'h3, 32'hCAFE, 32'h0, 2'b00, 4'd2, 1'b0, 32'h0, 1'b1);
        @(negedge clock);
        check("ph1_ebp", ebp, 32'hCAFE);
        check("ph1_eip_unchanged", eip, 32'h0);
        drain();

        // push then pop
        issue(4'h3, 4'h3, 32'h1, 32'h2, 2'b01, 4'd0, 1'b0, 32'h0, 1'b1);
        issue(4'h3, 4'h3, 32'h3, 32'h4, 2'b10, 4'd0, 1'b0, 32'h0, 1'b1);
        // pop with explicit esp write, plus jump
        issue(4'h0, 4'h4, 32'h0, 32'h2000, 2'b10, 4'd3, 1'b1, 32'h40, 1'b1);
        // esp to zero, then push wraps
        issue(4'h1, 4'h0, 32'h0, 32'h0, 2'b00, 4'd1, 1'b0, 32'h0, 1'b1);
        issue(4'h3, 4'h3, 32'h0, 32'h0, 2'b01, 4'd1, 1'b0, 32'h0, 1'b1);
        // eip wrap
        issue(4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 4'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        issue(4'h0, 4'h0, 32'h0, 32'h0, 2'b11, 4'd1, 1'b0, 32'h0, 1'b1);
        drain();
        check("wrap_esp", esp, 32'hFFFF_FFFC);
        check("wrap_eip", eip, 32'h0);

        // Randomized traffic with idle gaps
        for (int i = 0; i < 60; i++) begin
            s1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
            s2 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
            issue(s1, s2, $urandom, $urandom, 2'($urandom), 4'($urandom),
                  1'($urandom_range(0, 4) == 0), $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        drain();

        // Reset during phase 2 discards the transaction
        issue(4'h3, 4'h2, 32'h0, 32'h5, 2'b00, 4'd4, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ebp", ebp, 32'h0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        m_eip = 32'h0; m_ebp = 32'h0; m_esp = 32'h1000;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_done", {31'd0, done}, 32'd0);
        end
        check("post_rst_ready", {31'd0, wr_ready}, 32'd1);
        check("post_rst_ebp", ebp, 32'h0);
        check("post_rst_eip", eip, 32'h0);
        check("post_rst_esp", esp, 32'h1000);

        // Block is back in IDLE and fully functional
        issue(4'h2, 4'h1, 32'h77, 32'h800, 2'b01, 4'd6, 1'b0, 32'h0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
